// File: rtl/hood_mode_ctrl_if.sv
// Front-panel and smoker-side signal bundle for the range-hood mode controller.
// Latency: none (wiring only).
// Backpressure: none; buttons are raw levels, outputs are registered levels.
// Optional mode_led field is present only when HOOD_MODE_LED_EN is defined.
interface hood_mode_ctrl_if;
    logic       power_btn;
    logic       menu_btn;
    logic       lvl1_btn;
    logic       lvl2_btn;
    logic       lvl3_btn;
    logic       return_state;
    logic       hurricane_mode_enabled;
    logic [2:0] mode_state;
    logic       menu_level;
    logic       l3_fault;
`ifdef HOOD_MODE_LED_EN
    logic [4:0] mode_led;

    modport master (
        output power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn,
        output return_state, hurricane_mode_enabled,
        input  mode_state, menu_level, l3_fault, mode_led
    );

    modport slave (
        input  power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn,
        input  return_state, hurricane_mode_enabled,
        output mode_state, menu_level, l3_fault, mode_led
    );
`else
    modport master (
        output power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn,
        output return_state, hurricane_mode_enabled,
        input  mode_state, menu_level, l3_fault
    );

    modport slave (
        input  power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn,
        input  return_state, hurricane_mode_enabled,
        output mode_state, menu_level, l3_fault
    );
`endif
endinterface

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: debounced front-panel buttons drive OFF/STANDBY/L1/L2/L3 with an L3 watchdog.
// Latency: raw button edge to press pulse 2+DEBOUNCE_CYC+1 cycles, mode_state one cycle later.
// Backpressure: none; presses arriving while they have no effect are dropped. Optional LED: HOOD_MODE_LED_EN.
module hood_mode_ctrl #(
    parameter int CLK_HZ       = 500,
    parameter int DEBOUNCE_CYC = 10,
    parameter int L3_MAX_SEC   = 65
) (
    input  logic            clk,
    input  logic            rst,
    hood_mode_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
    localparam int PRE_W = $clog2(CLK_HZ) + 1;
    localparam int SEC_W = $clog2(L3_MAX_SEC) + 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF  = PRE_W'(CLK_HZ / 2 - 1);
    localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(L3_MAX_SEC - 1);

    // Button bit positions; lower index means higher priority.
    localparam int B_PWR  = 0;
    localparam int B_MENU = 1;
    localparam int B_L3   = 2;
    localparam int B_L2   = 3;
    localparam int B_L1   = 4;

    typedef enum logic [2:0] {
        ST_STANDBY = 3'b000,
        ST_L1      = 3'b001,
        ST_L2      = 3'b010,
        ST_L3      = 3'b011,
        ST_OFF     = 3'b100
    } state_e;

    logic [4:0]       raw_btn;
    logic [4:0]       s1_q;
    logic [4:0]       s2_q;
    logic [4:0]       acc_q;
    logic [4:0]       acc_prev_q;
    logic [4:0]       press_q;
    logic [4:0]       armed_q;
    logic [CNT_W-1:0] cnt_q [5];
    logic [1:0]       sync_fill_q;

    logic             hme_q;
    logic             hme_fall;

    logic [PRE_W-1:0] pre_q;
    logic [SEC_W-1:0] sec_q;
    logic             tick;
    logic             wd_expire;

    logic             act_power;
    logic             act_menu;
    logic             act_l3;
    logic             act_l2;
    logic             act_l1;

    state_e           state_q;
    state_e           state_d;
    logic             l3_fault_q;
    logic             l3_fault_d;

    assign raw_btn = {bus.lvl1_btn, bus.lvl2_btn, bus.lvl3_btn, bus.menu_btn, bus.power_btn};

    // Synchronise, debounce and edge-detect all five buttons; a button held
    // through reset stays disarmed until it is seen released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            acc_q       <= '0;
            acc_prev_q  <= '0;
            press_q     <= '0;
            armed_q     <= '0;
            sync_fill_q <= '0;
            for (int b = 0; b < 5; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            s1_q       <= raw_btn;
            s2_q       <= s1_q;
            acc_prev_q <= acc_q;
            press_q    <= acc_q & ~acc_prev_q & armed_q;
            if (sync_fill_q != 2'd2) begin
                sync_fill_q <= sync_fill_q + 2'd1;
            end
            for (int b = 0; b < 5; b++) begin
                if (sync_fill_q == 2'd2 && !s2_q[b]) begin
                    armed_q[b] <= 1'b1;
                end
                if (s2_q[b] == acc_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == DB_LAST) begin
                    acc_q[b] <= s2_q[b];
                    cnt_q[b] <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    // Only the highest-priority press of a cycle is allowed to act.
    always_comb begin
        act_power = press_q[B_PWR];
        act_menu  = press_q[B_MENU] & ~press_q[B_PWR];
        act_l3    = press_q[B_L3]   & ~|press_q[B_MENU:B_PWR];
        act_l2    = press_q[B_L2]   & ~|press_q[B_L3:B_PWR];
        act_l1    = press_q[B_L1]   & ~|press_q[B_L2:B_PWR];
    end

    // Track the enable every cycle so a fall is seen regardless of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hme_q <= 1'b0;
        end else begin
            hme_q <= bus.hurricane_mode_enabled;
        end
    end

    assign hme_fall  = hme_q & ~bus.hurricane_mode_enabled;
    assign tick      = (pre_q == PRE_LAST);
    assign wd_expire = tick && (sec_q == SEC_LAST);

    // Next-state decode; in L3 the smoker's exit edge outranks the watchdog.
    always_comb begin
        state_d    = state_q;
        l3_fault_d = l3_fault_q;
        case (state_q)
            ST_OFF: begin
                if (act_power) state_d = ST_STANDBY;
            end
            ST_STANDBY: begin
                if (act_power)                                   state_d = ST_OFF;
                else if (act_l3 && bus.hurricane_mode_enabled)   state_d = ST_L3;
                else if (act_l2)                                 state_d = ST_L2;
                else if (act_l1)                                 state_d = ST_L1;
            end
            ST_L1, ST_L2: begin
                if (act_power)     state_d = ST_OFF;
                else if (act_menu) state_d = ST_STANDBY;
                else if (act_l2)   state_d = ST_L2;
                else if (act_l1)   state_d = ST_L1;
            end
            ST_L3: begin
                if (hme_fall) begin
                    state_d = bus.return_state ? ST_L2 : ST_STANDBY;
                end else if (wd_expire) begin
                    state_d    = ST_L2;
                    l3_fault_d = 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Watchdog prescaler and seconds counter run only while staying in L3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
            sec_q <= '0;
        end else if (state_q == ST_L3 && state_d == ST_L3) begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                sec_q <= sec_q + SEC_W'(1);
            end
        end else begin
            pre_q <= '0;
            sec_q <= '0;
        end
    end

`ifdef HOOD_MODE_LED_EN
    logic [4:0] led_q;
    logic [4:0] led_d;
    logic       half_tick;

    assign half_tick = (pre_q == PRE_HALF) || tick;

    // One-hot LED follows the next state; the L3 lamp toggles each half second.
    always_comb begin
        led_d = 5'b10000;
        case (state_d)
            ST_STANDBY: led_d = 5'b00001;
            ST_L1:      led_d = 5'b00010;
            ST_L2:      led_d = 5'b00100;
            ST_L3: begin
                if (state_q != ST_L3) led_d = 5'b01000;
                else if (half_tick)   led_d = led_q ^ 5'b01000;
                else                  led_d = led_q;
            end
            default:    led_d = 5'b10000;
        endcase
    end

    // Mode register with sticky watchdog fault and LED image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            l3_fault_q <= 1'b0;
            led_q      <= 5'b10000;
        end else begin
            state_q    <= state_d;
            l3_fault_q <= l3_fault_d;
            led_q      <= led_d;
        end
    end

    assign bus.mode_led = led_q;
`else
    // Mode register with sticky watchdog fault.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            l3_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            l3_fault_q <= l3_fault_d;
        end
    end
`endif

    assign bus.mode_state = state_q;
    assign bus.menu_level = acc_q[B_MENU];
    assign bus.l3_fault   = l3_fault_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl: vector table for single presses plus sequences for L3, watchdog and reset.
// Latency: button held 12 cycles, state expected 2 cycles after release.
// Backpressure: n/a.
module tb_hood_mode_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hood_mode_ctrl_if bus();

    hood_mode_ctrl #(
        .CLK_HZ       (4),
        .DEBOUNCE_CYC (10),
        .L3_MAX_SEC   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] btn;   // {lvl1,lvl2,lvl3,menu,power}
        logic       hme;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl [13];

    localparam logic [4:0] PWR  = 5'b00001;
    localparam logic [4:0] MENU = 5'b00010;
    localparam logic [4:0] LV3  = 5'b00100;
    localparam logic [4:0] LV2  = 5'b01000;
    localparam logic [4:0] LV1  = 5'b10000;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btns(input logic [4:0] b);
        bus.power_btn = b[0];
        bus.menu_btn  = b[1];
        bus.lvl3_btn  = b[2];
        bus.lvl2_btn  = b[3];
        bus.lvl1_btn  = b[4];
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int onehot(input logic [2:0] s);
        case (s)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b011:  return 8;
            default: return 16;
        endcase
    endfunction

    task automatic chk_state(input string nm, input logic [2:0] exp);
        chk(nm, int'(bus.mode_state), int'(exp));
`ifdef HOOD_MODE_LED_EN
        if (exp != 3'b011) chk({nm, "_led"}, int'(bus.mode_led), onehot(exp));
`endif
    endtask

    // Hold buttons for 12 cycles, then release; returns just after edge 12.
    task automatic press(input logic [4:0] b);
        set_btns(b);
        cyc(12);
        set_btns(5'b0);
    endtask

    // Enter L3 from STANDBY; returns just after the entry edge.
    task automatic enter_l3();
        bus.hurricane_mode_enabled = 1'b1;
        press(LV3);
        cyc(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0]  = '{"stby_lvl2",      LV2,        1'b0, 3'b010};
        tbl[1]  = '{"l2_lvl1",        LV1,        1'b0, 3'b001};
        tbl[2]  = '{"l1_lvl3_ignored",LV3,        1'b1, 3'b001};
        tbl[3]  = '{"l1_menu",        MENU,       1'b0, 3'b000};
        tbl[4]  = '{"stby_lvl3_noen", LV3,        1'b0, 3'b000};
        tbl[5]  = '{"lvl2_over_lvl1", LV2 | LV1,  1'b0, 3'b010};
        tbl[6]  = '{"menu_over_lvl2", MENU | LV2, 1'b0, 3'b000};
        tbl[7]  = '{"stby_power",     PWR,        1'b0, 3'b100};
        tbl[8]  = '{"off_lvl1_ign",   LV1,        1'b0, 3'b100};
        tbl[9]  = '{"off_power",      PWR,        1'b0, 3'b000};
        tbl[10] = '{"stby_lvl1",      LV1,        1'b0, 3'b001};
        tbl[11] = '{"power_over_menu",PWR | MENU, 1'b0, 3'b100};
        tbl[12] = '{"off_power2",     PWR,        1'b0, 3'b000};

        rst = 1'b0;
        set_btns(5'b0);
        bus.return_state           = 1'b0;
        bus.hurricane_mode_enabled = 1'b0;
        cyc(3);
        chk_state("reset_state", 3'b100);
        chk("reset_menu", int'(bus.menu_level), 0);
        chk("reset_fault", int'(bus.l3_fault), 0);
        rst = 1'b1;
        cyc(5);

        // Power press latency: state still OFF at edge 13, STANDBY at edge 14.
        press(PWR);
        cyc(1);
        chk_state("pwr_edge13", 3'b100);
        cyc(1);
        chk_state("pwr_edge14", 3'b000);
        cyc(14);

        for (int i = 0; i < 13; i++) begin
            bus.hurricane_mode_enabled = tbl[i].hme;
            press(tbl[i].btn);
            cyc(2);
            chk_state(tbl[i].name, tbl[i].exp);
            cyc(14);
        end
        bus.hurricane_mode_enabled = 1'b0;

        // Bouncing lvl1 never settles long enough to be accepted.
        for (int i = 0; i < 5; i++) begin
            bus.lvl1_btn = 1'b1;
            cyc(3);
            bus.lvl1_btn = 1'b0;
            cyc(3);
        end
        chk_state("bounce_mid", 3'b000);
        cyc(16);
        chk_state("bounce_end", 3'b000);

        // L3 exit to L2 on enable fall with return_state=1.
        enter_l3();
        chk_state("l3_entry_a", 3'b011);
        bus.return_state           = 1'b1;
        bus.hurricane_mode_enabled = 1'b0;
        cyc(1);
        chk_state("l3_exit_l2", 3'b010);
        cyc(14);
        press(MENU);
        cyc(2);
        chk_state("l2_menu_stby", 3'b000);
        cyc(14);

        // L3 exit to STANDBY with return_state=0.
        enter_l3();
        chk_state("l3_entry_b", 3'b011);
        bus.return_state           = 1'b0;
        bus.hurricane_mode_enabled = 1'b0;
        cyc(1);
        chk_state("l3_exit_stby", 3'b000);
        cyc(14);

        // Menu held while in L3: level forwarded, state unchanged.
        bus.hurricane_mode_enabled = 1'b1;
        bus.lvl3_btn = 1'b1;
        cyc(3);
        bus.menu_btn = 1'b1;
        cyc(9);
        bus.lvl3_btn = 1'b0;
        cyc(8);
        chk_state("l3_menu_state", 3'b011);
        chk("l3_menu_level", int'(bus.menu_level), 1);
        bus.hurricane_mode_enabled = 1'b0;
        cyc(1);
        chk_state("l3_menu_exit", 3'b000);
        bus.menu_btn = 1'b0;
        cyc(16);
        chk("menu_level_low", int'(bus.menu_level), 0);

        // Exit edge coincides with watchdog expiry: exit wins, no fault.
        enter_l3();
        cyc(11);
        chk_state("coinc_pre", 3'b011);
        bus.hurricane_mode_enabled = 1'b0;
        cyc(1);
        chk_state("coinc_state", 3'b000);
        chk("coinc_fault", int'(bus.l3_fault), 0);
        cyc(14);

        // Watchdog expiry: 12 cycles in L3 with enable stuck high.
        enter_l3();
        chk_state("wd_entry", 3'b011);
`ifdef HOOD_MODE_LED_EN
        chk("led_blink0", int'(bus.mode_led), 8);
        cyc(2);
        chk("led_blink1", int'(bus.mode_led), 0);
        cyc(2);
        chk("led_blink2", int'(bus.mode_led), 8);
        cyc(7);
`else
        cyc(11);
`endif
        chk_state("wd_before", 3'b011);
        chk("wd_fault_before", int'(bus.l3_fault), 0);
        cyc(1);
        chk_state("wd_expired", 3'b010);
        chk("wd_fault_set", int'(bus.l3_fault), 1);
        cyc(14);
        chk("wd_fault_sticky", int'(bus.l3_fault), 1);

        // Reset in L2 returns to OFF immediately and clears the fault.
        #1;
        rst = 1'b0;
        #1;
        chk_state("rst_mid_state", 3'b100);
        chk("rst_mid_fault", int'(bus.l3_fault), 0);

        // Power held through reset must not produce a press.
        bus.power_btn = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(20);
        chk_state("held_thru_rst", 3'b100);
        bus.power_btn = 1'b0;
        cyc(16);
        press(PWR);
        cyc(2);
        chk_state("repress_after_rst", 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
